// File: rtl/gbar_arbiter.sv
// Cluster global barrier controller: round-robin arbitration of per-core barrier
// arrivals, per-barrier arrival masks, and a one-cycle release broadcast.
module gbar_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
  input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic                          rsp_valid,
  output logic [NB_WIDTH-1:0]           rsp_id,
  output logic                          err_valid,
  output logic                          busy
);

  // A barrier is idle when its mask is zero and collecting otherwise.
  logic [NUM_CORES-1:0] r_mask [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  r_size [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  r_rr_ptr;
  logic                 r_rsp_valid;
  logic [NB_WIDTH-1:0]  r_rsp_id;
  logic                 r_err_valid;
  logic                 r_busy;

  logic                 w_gnt_any;
  logic [NC_WIDTH-1:0]  w_gnt_idx;
  int                   w_cand;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_cand = (int'(r_rr_ptr) + i) % NUM_CORES;
      if (!w_gnt_any && req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = NC_WIDTH'(w_cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && w_gnt_any) req_ready[w_gnt_idx] = 1'b1;
  end

  logic [NB_WIDTH-1:0]  w_sel_id;
  logic [NC_WIDTH-1:0]  w_sel_size;
  logic                 w_size_bad;
  logic                 w_id_bad;

  assign w_sel_id   = req_id[int'(w_gnt_idx)*NB_WIDTH +: NB_WIDTH];
  assign w_sel_size = req_size_m1[int'(w_gnt_idx)*NC_WIDTH +: NC_WIDTH];
  assign w_size_bad = int'(w_sel_size) >= NUM_CORES;
  // IDs beyond NUM_BARRIERS (non power-of-two counts) are rejected like bad sizes.
  assign w_id_bad   = int'(w_sel_id) >= NUM_BARRIERS;

  logic [NUM_CORES-1:0] w_mask_nxt [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  w_size_nxt [NUM_BARRIERS];
  logic [NUM_CORES-1:0] w_cur_mask;
  logic [NC_WIDTH:0]    w_pop;
  logic [NC_WIDTH-1:0]  w_ptr_nxt;
  logic                 w_rsp_nxt;
  logic [NB_WIDTH-1:0]  w_rsp_id_nxt;
  logic                 w_err_nxt;
  logic                 w_busy_nxt;

  always_comb begin
    w_mask_nxt   = r_mask;
    w_size_nxt   = r_size;
    w_ptr_nxt    = r_rr_ptr;
    w_rsp_nxt    = 1'b0;
    w_rsp_id_nxt = r_rsp_id;
    w_err_nxt    = 1'b0;
    w_cur_mask   = r_mask[w_sel_id];
    w_pop        = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      w_pop = w_pop + {{NC_WIDTH{1'b0}}, w_cur_mask[j]};
    end
    if (w_gnt_any) begin
      w_ptr_nxt = NC_WIDTH'((int'(w_gnt_idx) + 1) % NUM_CORES);
      if (w_size_bad || w_id_bad) begin
        w_err_nxt = 1'b1;
      end else if (w_cur_mask[w_gnt_idx]) begin
        w_err_nxt = 1'b1;
      end else if ((|w_cur_mask) && (w_sel_size != r_size[w_sel_id])) begin
        w_err_nxt = 1'b1;
      end else begin
        if (!(|w_cur_mask)) w_size_nxt[w_sel_id] = w_sel_size;
        // Arrivals so far equal size_m1: this arrival is the last one.
        if (w_pop == {1'b0, w_sel_size}) begin
          w_mask_nxt[w_sel_id] = '0;
          w_rsp_nxt            = 1'b1;
          w_rsp_id_nxt         = w_sel_id;
        end else begin
          w_mask_nxt[w_sel_id][w_gnt_idx] = 1'b1;
        end
      end
    end
    w_busy_nxt = w_rsp_nxt;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      w_busy_nxt = w_busy_nxt | (|w_mask_nxt[b]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_mask[b] <= '0;
        r_size[b] <= '0;
      end
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_err_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mask      <= w_mask_nxt;
      r_size      <= w_size_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      r_rsp_valid <= w_rsp_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_err_valid <= w_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign err_valid = r_err_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gbar_arbiter.sv
// Scoreboard bench for gbar_arbiter: directed scenarios plus random traffic,
// predicted by a set-based barrier model and checked by a negedge monitor.
module tb_gbar_arbiter;
  localparam int NC = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]   req_valid = '0;
  logic [NC*2-1:0] req_id = '0;
  logic [NC*2-1:0] req_size_m1 = '0;
  logic [NC-1:0]   req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic            err_valid;
  logic            busy;

  gbar_arbiter #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
    .req_size_m1(req_size_m1), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .err_valid(err_valid), .busy(busy)
  );

  // Three-core instance: size_m1=3 is representable yet out of range.
  logic [2:0] s_valid = '0;
  logic [2:0] s_id = '0;
  logic [5:0] s_size = '0;
  logic [2:0] s_ready;
  logic       s_rsp;
  logic [0:0] s_rsp_id;
  logic       s_err;
  logic       s_busy;

  gbar_arbiter #(.NUM_CORES(3), .NUM_BARRIERS(2)) dut3 (
    .clk(clk), .reset(reset), .req_valid(s_valid), .req_id(s_id),
    .req_size_m1(s_size), .req_ready(s_ready), .rsp_valid(s_rsp),
    .rsp_id(s_rsp_id), .err_valid(s_err), .busy(s_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rsp;
    logic [1:0] id;
    logic       err;
    logic       busy;
  } out_t;

  out_t       q_out[$];
  logic [3:0] q_gnt[$];
  bit         mon_en = 1'b0;

  // Reference model: set of arrived cores and agreed size per barrier.
  bit m_arr[NB][NC];
  int m_size[NB];
  int m_ptr;
  bit p_v[NC];
  int p_id[NC];
  int p_sz[NC];

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_size[b] = 0;
      for (int c = 0; c < NC; c++) m_arr[b][c] = 1'b0;
    end
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic step();
    int   k, b, s, cnt;
    out_t o;
    logic [3:0] g;
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) begin
      req_valid[c]          = p_v[c];
      req_id[c*2 +: 2]      = 2'(p_id[c]);
      req_size_m1[c*2 +: 2] = 2'(p_sz[c]);
    end
    k = -1;
    for (int i = 0; i < NC; i++) if (k < 0 && p_v[(m_ptr + i) % NC]) k = (m_ptr + i) % NC;
    g = '0;
    o = '{rsp: 1'b0, id: 2'd0, err: 1'b0, busy: 1'b0};
    if (k >= 0) begin
      g[k]   = 1'b1;
      m_ptr  = (k + 1) % NC;
      b      = p_id[k];
      s      = p_sz[k];
      p_v[k] = 1'b0;
      cnt = 0;
      for (int c = 0; c < NC; c++) cnt += int'(m_arr[b][c]);
      if (s >= NC) o.err = 1'b1;
      else if (m_arr[b][k]) o.err = 1'b1;
      else if (cnt > 0 && s != m_size[b]) o.err = 1'b1;
      else if (cnt == s) begin
        for (int c = 0; c < NC; c++) m_arr[b][c] = 1'b0;
        o.rsp = 1'b1;
        o.id  = 2'(b);
      end else begin
        if (cnt == 0) m_size[b] = s;
        m_arr[b][k] = 1'b1;
      end
    end
    o.busy = o.rsp;
    for (int bb = 0; bb < NB; bb++)
      for (int c = 0; c < NC; c++) o.busy = o.busy | m_arr[bb][c];
    q_gnt.push_back(g);
    q_out.push_back(o);
  endtask

  task automatic request(input int c, input int id, input int sz);
    p_v[c]  = 1'b1;
    p_id[c] = id;
    p_sz[c] = sz;
  endtask

  task automatic run_until_idle();
    int  guard = 0;
    bit  any;
    any = 1'b1;
    while (any && guard < 50) begin
      step();
      guard++;
      any = 1'b0;
      for (int c = 0; c < NC; c++) any = any | p_v[c];
    end
    if (any) check("drain_timeout", 32'(guard), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [3:0] g;
    out_t       o;
    if (mon_en) begin
      if (q_gnt.size() > 0) begin
        g = q_gnt.pop_front();
        check("req_ready", 32'(req_ready), 32'(g));
      end
      if (q_out.size() > 0) begin
        o = q_out.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(o.rsp));
        check("err_valid", 32'(err_valid), 32'(o.err));
        check("busy", 32'(busy), 32'(o.busy));
        if (o.rsp) check("rsp_id", 32'(rsp_id), 32'(o.id));
      end
    end
  end

  task automatic start_monitor();
    q_gnt.delete();
    q_out.delete();
    q_out.push_back('{rsp: 1'b0, id: 2'd0, err: 1'b0, busy: 1'b0});
    mon_en = 1'b1;
  endtask

  int pref[NB];

  initial begin
    model_reset();
    for (int c = 0; c < NC; c++) begin p_id[c] = 0; p_sz[c] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    start_monitor();

    // Fairness: two all-core bursts, pointer wraps back to core 0.
    for (int c = 0; c < NC; c++) request(c, 0, 3);
    run_until_idle();
    for (int c = 0; c < NC; c++) request(c, 1, 3);
    run_until_idle();

    // Basic release, one arrival per cycle, then watch busy fall.
    for (int c = 0; c < NC; c++) begin
      request(c, 2, 3);
      step();
    end
    step();
    step();

    // Interleaved barriers 0 and 3.
    request(0, 0, 1); request(1, 0, 1); request(2, 3, 1); request(3, 3, 1);
    run_until_idle();
    step();

    // Duplicate and size-mismatch errors, then complete barrier 0.
    request(1, 0, 3); step();
    request(1, 0, 3); step();
    request(2, 0, 2); step();
    request(0, 0, 3); request(2, 0, 3); request(3, 0, 3);
    run_until_idle();
    step();

    // Epoch reuse with size_m1=0.
    request(0, 1, 0); step();
    request(0, 1, 0); step();
    step();
    step();

    // Asynchronous reset mid-collection.
    request(0, 1, 3); request(1, 1, 3);
    run_until_idle();
    step();
    #1;
    mon_en    = 1'b0;
    req_valid = '1;
    reset     = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    model_reset();
    #1;
    start_monitor();
    for (int c = 0; c < NC; c++) request(c, 1, 3);
    run_until_idle();
    step();

    // Random traffic.
    for (int b = 0; b < NB; b++) pref[b] = int'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 150 == 149) for (int b = 0; b < NB; b++) pref[b] = int'($urandom_range(0, 3));
      for (int c = 0; c < NC; c++) begin
        if (!p_v[c] && $urandom_range(0, 1) == 1) begin
          int id;
          id = int'($urandom_range(0, NB - 1));
          request(c, id, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : pref[id]);
        end
      end
      step();
    end
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    step();
    repeat (2) @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drain", 32'(q_gnt.size() + q_out.size()), 32'd0);

    // Out-of-range size on the three-core instance.
    @(posedge clk); #1;
    s_valid = 3'b001; s_id = 3'b000; s_size = 6'b00_00_11;
    #3;
    check("size_err_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 3'b000;
    check("size_err_pulse", 32'(s_err), 32'd1);
    check("size_err_busy", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    check("size_err_clear", 32'(s_err), 32'd0);
    s_valid = 3'b001; s_size = 6'b00_00_10;
    @(posedge clk); #1;
    s_valid = 3'b000;
    check("size_ok_err", 32'(s_err), 32'd0);
    check("size_ok_busy", 32'(s_busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
